ins_mem_arbiter: RTL and testbench

- Shares one single-port instruction RAM between CORE_COUNT processor cores and the host program loader.
- The RAM has a write latency of 1 clock. It registers its address, so read data is valid in the cycle after the address is presented.
- The block sequences two phases. In LOAD, the host writes the program. In RUN, cores fetch instructions under round-robin arbitration at one grant per cycle.
- Each core receives a per-core read-valid strobe aligned to the RAM's read latency.

---
 rtl/ins_mem_arbiter_if.sv | 35 +++
 rtl/ins_mem_arbiter.sv | 105 ++++++++++
 tb/tb_ins_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ins_mem_arbiter_if.sv
// Bus bundle between the instruction-RAM arbiter, the host loader, the cores and the RAM.
// slave is the arbiter side. master is the environment side: host, cores and RAM.
interface ins_mem_arbiter_if #(
   parameter int CORE_COUNT = 4,
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
);
   logic                             start;
   logic                             done;
   logic                             load_wrEn;
   logic [ADDR_WIDTH-1:0]            load_addr;
   logic [WIDTH-1:0]                 load_data;
   logic [CORE_COUNT-1:0]            core_req;
   logic [CORE_COUNT*ADDR_WIDTH-1:0] core_addr;
   logic [CORE_COUNT-1:0]            core_gnt;
   logic [CORE_COUNT-1:0]            core_rvalid;
   logic [WIDTH-1:0]                 core_rdata;
   logic                             run;
   logic                             wr_err;
   logic                             ram_wrEn;
   logic [ADDR_WIDTH-1:0]            ram_addr;
   logic [WIDTH-1:0]                 ram_dataIn;
   logic [WIDTH-1:0]                 ram_dataOut;

   modport slave (
      input  start, done, load_wrEn, load_addr, load_data, core_req, core_addr, ram_dataOut,
      output core_gnt, core_rvalid, core_rdata, run, wr_err, ram_wrEn, ram_addr, ram_dataIn
   );

   modport master (
      output start, done, load_wrEn, load_addr, load_data, core_req, core_addr, ram_dataOut,
      input  core_gnt, core_rvalid, core_rdata, run, wr_err, ram_wrEn, ram_addr, ram_dataIn
   );
endinterface

// File: rtl/ins_mem_arbiter.sv
// Shares one single-port instruction RAM between the host loader (LOAD) and CORE_COUNT cores (RUN).
// Define INS_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module ins_mem_arbiter #(
   parameter int CORE_COUNT = 4,
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input logic              clk,
   input logic              rstN,
   ins_mem_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(CORE_COUNT);

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  gnt_any;
   logic [IDX_W-1:0]      gnt_idx;
   logic [IDX_W-1:0]      cand;
   logic [CORE_COUNT-1:0] gnt_vec;
   logic [CORE_COUNT-1:0] rvalid_q;
   logic                  wr_err_q;

`ifndef INS_ARB_FIXED_PRIO_EN
   logic [IDX_W-1:0]      rr_ptr;
`endif

   // First requesting core, scanning upward from the search origin.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < CORE_COUNT; k++) begin
`ifdef INS_ARB_FIXED_PRIO_EN
         cand = IDX_W'(k);
`else
         cand = IDX_W'((int'(rr_ptr) + k) % CORE_COUNT);
`endif
         if (!gnt_any && bus.core_req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt      = state;
      gnt_vec        = '0;
      bus.ram_wrEn   = 1'b0;
      bus.ram_addr   = '0;
      bus.ram_dataIn = '0;
      case (state)
         LOAD: begin
            bus.ram_wrEn   = bus.load_wrEn;
            bus.ram_addr   = bus.load_addr;
            bus.ram_dataIn = bus.load_data;
            if (bus.start) state_nxt = RUN;
         end
         RUN: begin
            if (gnt_any) begin
               gnt_vec[gnt_idx] = 1'b1;
               bus.ram_addr     = bus.core_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            end
            if (bus.done) state_nxt = LOAD;
         end
         default: state_nxt = LOAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state    <= LOAD;
         rvalid_q <= '0;
         wr_err_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         rvalid_q <= gnt_vec;
         if (state == RUN && bus.load_wrEn) wr_err_q <= 1'b1;
      end
   end

`ifndef INS_ARB_FIXED_PRIO_EN
   // Origin moves past the winner; idle cycles leave it where it is.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rr_ptr <= '0;
      end else if (gnt_vec != '0) begin
         rr_ptr <= (gnt_idx == IDX_W'(CORE_COUNT - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end
`endif

   assign bus.core_gnt    = gnt_vec;
   assign bus.core_rvalid = rvalid_q;
   assign bus.core_rdata  = bus.ram_dataOut;
   assign bus.run         = (state == RUN);
   assign bus.wr_err      = wr_err_q;
endmodule

// File: tb/tb_ins_mem_arbiter.sv
// Bench for ins_mem_arbiter with a behavioural RAM and a read-return scoreboard.
// Grants are checked combinationally; each expected grant queues its rvalid/rdata for the next cycle.
module tb_ins_mem_arbiter;
   localparam int CORES = 4;
   localparam int W     = 8;
   localparam int D     = 256;
   localparam int AW    = 8;

   typedef struct {
      logic [CORES-1:0] rv;
      logic [W-1:0]     data;
   } exp_t;

   logic clk = 1'b0;
   logic rstN;
   always #5 clk = ~clk;

   ins_mem_arbiter_if #(.CORE_COUNT(CORES), .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) bus ();

   ins_mem_arbiter #(.CORE_COUNT(CORES), .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
   );

   // Single-port RAM: write lands at the edge, address is registered for the read.
   logic [W-1:0]  mem [D];
   logic [AW-1:0] addr_q;
   always @(posedge clk) begin
      if (bus.ram_wrEn) mem[bus.ram_addr] <= bus.ram_dataIn;
      addr_q <= bus.ram_addr;
   end
   assign bus.ram_dataOut = mem[addr_q];

   logic [W-1:0]  shadow   [D];
   logic [AW-1:0] req_addr [CORES];
   exp_t          sb [$];
   exp_t          e;
   int            n_cmp = 0;
   int            n_err = 0;

   task automatic set_req(input logic [CORES-1:0] req);
      bus.core_req = req;
      for (int i = 0; i < CORES; i++) bus.core_addr[i*AW +: AW] = req_addr[i];
   endtask

   task automatic sb_push(input logic [CORES-1:0] gnt);
      for (int i = 0; i < CORES; i++)
         if (gnt[i]) sb.push_back('{rv: gnt, data: shadow[req_addr[i]]});
   endtask

   // Each queued grant must come back as rvalid/rdata exactly one cycle later.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if (bus.core_rvalid !== e.rv || bus.core_rdata !== e.data) begin
            n_err++;
            $display("FAIL rvalid_rdata: got %b/%h required %b/%h", bus.core_rvalid, bus.core_rdata, e.rv, e.data);
         end
      end else if (bus.core_rvalid !== '0) begin
         n_cmp++;
         n_err++;
         $display("FAIL unexpected_rvalid: got %b required 0000", bus.core_rvalid);
      end
   end

   task automatic test_reset();
      rstN = 1'b0;
      bus.start = 1'b0; bus.done = 1'b0;
      bus.load_wrEn = 1'b0; bus.load_addr = '0; bus.load_data = '0;
      for (int i = 0; i < CORES; i++) req_addr[i] = '0;
      set_req('0);
      #2;
      n_cmp++;
      if ({bus.core_rvalid, bus.core_gnt, bus.ram_wrEn, bus.run, bus.wr_err} !== 11'b0) begin
         n_err++;
         $display("FAIL reset_state: rvalid=%b gnt=%b wrEn=%b run=%b wr_err=%b required all 0",
                  bus.core_rvalid, bus.core_gnt, bus.ram_wrEn, bus.run, bus.wr_err);
      end
      @(negedge clk);
      rstN = 1'b1;
   endtask

   task automatic test_load_and_fetch();
      logic [W-1:0] d;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         d = (i == 3) ? 8'hA5 : (i == 4) ? 8'h5A : 8'(8'h10 + i * 8'h11);
         bus.load_wrEn = 1'b1; bus.load_addr = AW'(i); bus.load_data = d;
         shadow[i] = d;
         req_addr[1] = 8'd7;
         set_req((i == 1) ? 4'b0010 : 4'b0000);
         #1;
         n_cmp++;
         if (bus.ram_wrEn !== 1'b1 || bus.ram_addr !== AW'(i) || bus.ram_dataIn !== d || bus.core_gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL load_write: wrEn=%b addr=%h data=%h gnt=%b required 1/%h/%h/0000",
                     bus.ram_wrEn, bus.ram_addr, bus.ram_dataIn, bus.core_gnt, AW'(i), d);
         end
      end
      @(negedge clk);
      bus.load_wrEn = 1'b0; bus.start = 1'b1;
      set_req('0);
      #1;
      n_cmp++;
      if (bus.run !== 1'b0) begin n_err++; $display("FAIL run_before_start: got %b required 0", bus.run); end
      @(negedge clk);
      bus.start = 1'b0;
      req_addr[0] = 8'd3;
      set_req(4'b0001);
      #1;
      n_cmp++;
      if (bus.run !== 1'b1 || bus.core_gnt !== 4'b0001 || bus.ram_addr !== 8'd3) begin
         n_err++;
         $display("FAIL first_fetch: run=%b gnt=%b addr=%h required 1/0001/03", bus.run, bus.core_gnt, bus.ram_addr);
      end
      sb_push(4'b0001);
      @(negedge clk);
      req_addr[3] = 8'd4;
      set_req(4'b1000);
      #1;
      n_cmp++;
      if (bus.core_gnt !== 4'b1000 || bus.ram_addr !== 8'd4) begin
         n_err++;
         $display("FAIL fetch_core3: gnt=%b addr=%h required 1000/04", bus.core_gnt, bus.ram_addr);
      end
      sb_push(4'b1000);
      @(negedge clk);
      set_req('0);
      #1;
      n_cmp++;
      if (bus.core_gnt !== 4'b0000 || bus.ram_addr !== '0) begin
         n_err++;
         $display("FAIL idle_run: gnt=%b addr=%h required 0000/00", bus.core_gnt, bus.ram_addr);
      end
   endtask

   task automatic test_back_to_back();
      logic [CORES-1:0] req;
      logic [CORES-1:0] got;
      @(negedge clk);
      for (int i = 0; i < CORES; i++) req_addr[i] = AW'(i);
      req = 4'b1111;
      set_req(req);
      for (int k = 0; k < CORES; k++) begin
         #1;
         got = bus.core_gnt;
         n_cmp++;
         if (got !== 4'(1 << k)) begin
            n_err++;
            $display("FAIL all_four_grant%0d: got %b required %b", k, got, 4'(1 << k));
         end
         sb_push(4'(1 << k));
         @(negedge clk);
         req = req & ~got;
         set_req(req);
      end
      // Origin wrapped back to core 0: of cores 0 and 3, core 0 wins first.
      req_addr[0] = 8'd5; req_addr[3] = 8'd6;
      set_req(4'b1001);
      #1;
      n_cmp++;
      if (bus.core_gnt !== 4'b0001) begin n_err++; $display("FAIL rr_wrap_a: got %b required 0001", bus.core_gnt); end
      sb_push(4'b0001);
      @(negedge clk);
      set_req(4'b1000);
      #1;
      n_cmp++;
      if (bus.core_gnt !== 4'b1000) begin n_err++; $display("FAIL rr_wrap_b: got %b required 1000", bus.core_gnt); end
      sb_push(4'b1000);
      @(negedge clk);
      set_req('0);
   endtask

   task automatic test_starvation();
      logic [CORES-1:0] exp3;
      logic [CORES-1:0] req4;
      req_addr[0] = 8'd7; req_addr[1] = 8'd5; req_addr[2] = 8'd6;
      @(negedge clk);
      set_req(4'b0100);
      #1;
      n_cmp++;
      if (bus.core_gnt !== 4'b0100) begin n_err++; $display("FAIL starve_c1: got %b required 0100", bus.core_gnt); end
      sb_push(4'b0100);
      @(negedge clk);
      set_req(4'b0110);
      #1;
      n_cmp++;
      if (bus.core_gnt !== 4'b0010) begin n_err++; $display("FAIL starve_c2: got %b required 0010", bus.core_gnt); end
      sb_push(4'b0010);
      @(negedge clk);
      set_req(4'b0101);
`ifdef INS_ARB_FIXED_PRIO_EN
      exp3 = 4'b0001; req4 = 4'b0100;
`else
      exp3 = 4'b0100; req4 = 4'b0001;
`endif
      #1;
      n_cmp++;
      if (bus.core_gnt !== exp3) begin n_err++; $display("FAIL starve_c3: got %b required %b", bus.core_gnt, exp3); end
      sb_push(exp3);
      @(negedge clk);
      set_req(req4);
      #1;
      n_cmp++;
      if (bus.core_gnt !== req4) begin n_err++; $display("FAIL starve_c4: got %b required %b", bus.core_gnt, req4); end
      sb_push(req4);
      @(negedge clk);
      set_req('0);
   endtask

   task automatic test_wr_err();
      @(negedge clk);
      bus.load_wrEn = 1'b1; bus.load_addr = 8'd3; bus.load_data = 8'hFF;
      #1;
      n_cmp++;
      if (bus.ram_wrEn !== 1'b0 || bus.ram_dataIn !== '0 || bus.wr_err !== 1'b0) begin
         n_err++;
         $display("FAIL run_write_blocked: wrEn=%b dataIn=%h wr_err=%b required 0/00/0",
                  bus.ram_wrEn, bus.ram_dataIn, bus.wr_err);
      end
      @(negedge clk);
      bus.load_wrEn = 1'b0;
      #1;
      n_cmp++;
      if (bus.wr_err !== 1'b1) begin n_err++; $display("FAIL wr_err_set: got %b required 1", bus.wr_err); end
      @(negedge clk);
      req_addr[0] = 8'd3;
      set_req(4'b0001);
      #1;
      n_cmp++;
      if (bus.wr_err !== 1'b1 || bus.core_gnt !== 4'b0001) begin
         n_err++;
         $display("FAIL wr_err_sticky: wr_err=%b gnt=%b required 1/0001", bus.wr_err, bus.core_gnt);
      end
      sb_push(4'b0001);
      @(negedge clk);
      set_req('0);
   endtask

   task automatic test_done_grant();
      @(negedge clk);
      req_addr[3] = 8'd2;
      set_req(4'b1000);
      bus.done = 1'b1;
      #1;
      n_cmp++;
      if (bus.core_gnt !== 4'b1000) begin n_err++; $display("FAIL done_grant: got %b required 1000", bus.core_gnt); end
      sb_push(4'b1000);
      @(negedge clk);
      bus.done = 1'b0;
      req_addr[0] = 8'd1;
      set_req(4'b0001);
      #1;
      n_cmp++;
      if (bus.run !== 1'b0 || bus.core_gnt !== 4'b0000) begin
         n_err++;
         $display("FAIL load_after_done: run=%b gnt=%b required 0/0000", bus.run, bus.core_gnt);
      end
      @(negedge clk);
      set_req('0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.run !== 1'b1) begin n_err++; $display("FAIL restart_run: got %b required 1", bus.run); end
      @(negedge clk);
      bus.start = 1'b0;
      req_addr[1] = 8'd1;
      set_req(4'b0010);
      #1;
      n_cmp++;
      if (bus.run !== 1'b1 || bus.core_gnt !== 4'b0010) begin
         n_err++;
         $display("FAIL start_in_run: run=%b gnt=%b required 1/0010", bus.run, bus.core_gnt);
      end
      sb_push(4'b0010);
      @(posedge clk);
      #1;
      set_req('0);
      #1;
      n_cmp++;
      if (bus.core_rvalid !== 4'b0010) begin n_err++; $display("FAIL pre_reset_rvalid: got %b required 0010", bus.core_rvalid); end
      rstN = 1'b0;
      #1;
      sb.delete();
      n_cmp++;
      if ({bus.core_rvalid, bus.run, bus.wr_err, bus.core_gnt} !== 10'b0) begin
         n_err++;
         $display("FAIL async_reset: rvalid=%b run=%b wr_err=%b gnt=%b required 0",
                  bus.core_rvalid, bus.run, bus.wr_err, bus.core_gnt);
      end
      @(negedge clk);
      rstN = 1'b1;
   endtask

   initial begin
      test_reset();
      test_load_and_fetch();
      test_back_to_back();
      test_starvation();
      test_wr_err();
      test_done_grant();
      test_reset_mid();
      @(negedge clk);
      #1;
      n_cmp++;
      if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d pending required 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
